// File: rtl/ov7670_sccb.sv
// ov7670_sccb: 3-phase SCCB register writer for the OV7670 camera.
//
// Sends DEV_ADDR, register address and register value as one SCCB write
// transaction. SIOC runs at clk / (4*CLK_DIV); each bit spans 4 quarters.
//
// Parameters:
//   CLK_DIV  - clk cycles per SIOC quarter-period (minimum 2)
//   DEV_ADDR - 8-bit SCCB write ID sent in phase 1
//
// Ports:
//   clk      - core clock, all logic on rising edge
//   reset_n  - synchronous active-low reset
//   start    - request a write (accepted only in IDLE)
//   data     - [15:8] register address, [7:0] register value
//   busy     - transaction in progress
//   done     - one-cycle pulse at transaction end
//   sioc     - SCCB clock
//   siod_out - SCCB data drive value
//   siod_oe  - 1 = drive siod_out, 0 = release the pin
//   siod_in  - sampled SCCB data pin
//   nack     - acknowledge error flag
//
// Build option:
//   SCCB_ACK_CHECK_EN - when defined, siod_in is sampled at the first cycle
//   of Q2 of every don't-care bit; a 1 sets nack until the next accepted
//   start. When undefined, nack is tied low and siod_in is ignored.
//
// state | meaning
// IDLE  | bus idle, waiting for start
// START | start condition, 2 quarters
// BITS  | 27 bits, 4 quarters each, MSB first
// STOP  | stop condition, 3 quarters
// DONE  | single-cycle done pulse

module ov7670_sccb #(
  parameter int         CLK_DIV  = 250,
  parameter logic [7:0] DEV_ADDR = 8'h42
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [15:0] data,
  output logic        busy,
  output logic        done,
  output logic        sioc,
  output logic        siod_out,
  output logic        siod_oe,
  input  logic        siod_in,
  output logic        nack
);

  localparam int            QW    = $clog2(CLK_DIV);
  localparam logic [QW-1:0] QLOAD = QW'(CLK_DIV - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    BITS,
    STOP,
    DONE
  } state_t;

  state_t        state_q, state_d;
  logic [QW-1:0] qcnt_q;
  logic [1:0]    quarter_q;
  logic [4:0]    bit_cnt_q;
  logic [26:0]   frame_q;
  logic          q_tick;
  logic          accept;
  logic          is_x;

  // quarter timer is a down-counter; terminal count closes the quarter
  assign q_tick = (qcnt_q == '0);
  assign accept = (state_q == IDLE) && start;
  // frame layout: [26:19] id, [18] X, [17:10] addr, [9] X, [8:1] value, [0] X
  assign is_x   = (bit_cnt_q == 5'd18) || (bit_cnt_q == 5'd9) || (bit_cnt_q == 5'd0);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      qcnt_q    <= QLOAD;
      quarter_q <= 2'd0;
      bit_cnt_q <= 5'd26;
      frame_q   <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        frame_q <= {DEV_ADDR, 1'b1, data[15:8], 1'b1, data[7:0], 1'b1};
      end
      // every state starts at quarter 0 with a freshly loaded timer
      if ((state_d != state_q) || (state_q == IDLE) || (state_q == DONE)) begin
        qcnt_q    <= QLOAD;
        quarter_q <= 2'd0;
      end else if (q_tick) begin
        qcnt_q    <= QLOAD;
        quarter_q <= quarter_q + 2'd1;
      end else begin
        qcnt_q <= qcnt_q - QW'(1);
      end
      if (state_q != BITS) begin
        bit_cnt_q <= 5'd26;
      end else if (q_tick && (quarter_q == 2'd3) && (bit_cnt_q != 5'd0)) begin
        bit_cnt_q <= bit_cnt_q - 5'd1;
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    busy     = 1'b0;
    done     = 1'b0;
    sioc     = 1'b1;
    siod_out = 1'b1;
    siod_oe  = 1'b1;
    case (state_q)
      IDLE: begin
        if (start) state_d = START;
      end
      START: begin
        busy     = 1'b1;
        sioc     = (quarter_q == 2'd0);
        siod_out = 1'b0;
        if (q_tick && (quarter_q == 2'd1)) state_d = BITS;
      end
      BITS: begin
        busy     = 1'b1;
        sioc     = quarter_q[1];
        siod_out = frame_q[bit_cnt_q];
        siod_oe  = !is_x;
        if (q_tick && (quarter_q == 2'd3) && (bit_cnt_q == 5'd0)) state_d = STOP;
      end
      STOP: begin
        busy     = 1'b1;
        sioc     = (quarter_q != 2'd0);
        siod_out = (quarter_q == 2'd2);
        if (q_tick && (quarter_q == 2'd2)) state_d = DONE;
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

`ifdef SCCB_ACK_CHECK_EN
  logic nack_q;
  logic ack_sample;

  // first cycle of Q2 of a don't-care bit: timer has just been reloaded
  assign ack_sample = (state_q == BITS) && is_x && (quarter_q == 2'd2) && (qcnt_q == QLOAD);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      nack_q <= 1'b0;
    end else if (accept) begin
      nack_q <= 1'b0;
    end else if (ack_sample && siod_in) begin
      nack_q <= 1'b1;
    end
  end

  assign nack = nack_q;
`else
  logic unused_siod_in;
  assign unused_siod_in = siod_in;
  assign nack           = 1'b0;
`endif

endmodule

// File: tb/tb_ov7670_sccb.sv
module tb_ov7670_sccb;

  localparam int         D   = 4;
  localparam int         NQ  = 113;
  localparam logic [7:0] DEV = 8'h42;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic [15:0] data = 16'h0000;
  logic        siod_in = 1'b0;
  logic        busy, done, sioc, siod_out, siod_oe, nack;

  int checks = 0;
  int failures = 0;

  ov7670_sccb #(.CLK_DIV(D), .DEV_ADDR(DEV)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .data(data),
    .busy(busy), .done(done), .sioc(sioc), .siod_out(siod_out),
    .siod_oe(siod_oe), .siod_in(siod_in), .nack(nack)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] d;
    int          glitch;
    int          xbit;
    logic [7:0]  exp_addr;
    logic [7:0]  exp_val;
  } vec_t;

  vec_t vecs[4];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // bit b (0 = first on the wire) of the 27-bit write frame
  function automatic void model_bit(input logic [15:0] d, input int b,
                                    output logic v, output logic x);
    logic [7:0] dev;
    dev = DEV;
    x = (b == 8) || (b == 17) || (b == 26);
    v = 1'b1;
    if (b < 8)                  v = dev[7-b];
    else if (b >= 9 && b <= 16) v = d[15-(b-9)];
    else if (b >= 18 && b <= 25) v = d[7-(b-18)];
  endfunction

  // expected pins for quarter k of the transaction (0 = first START quarter)
  function automatic void model_q(input logic [15:0] d, input int k,
                                  output logic sc, output logic sd,
                                  output logic oe, output logic care);
    logic v, x;
    care = 1'b1;
    oe   = 1'b1;
    sc   = 1'b1;
    sd   = 1'b1;
    if (k == 0) begin
      sc = 1'b1; sd = 1'b0;
    end else if (k == 1) begin
      sc = 1'b0; sd = 1'b0;
    end else if (k == 110) begin
      sc = 1'b0; sd = 1'b0;
    end else if (k == 111) begin
      sc = 1'b1; sd = 1'b0;
    end else if (k == 112) begin
      sc = 1'b1; sd = 1'b1;
    end else begin
      model_bit(d, (k - 2) / 4, v, x);
      sc   = (((k - 2) % 4) >= 2);
      sd   = v;
      oe   = !x;
      care = !x;
    end
  endfunction

  function automatic logic [26:0] model_frame(input logic [15:0] d);
    logic [26:0] f;
    logic v, x;
    f = '0;
    for (int b = 0; b < 27; b++) begin
      model_bit(d, b, v, x);
      f = {f[25:0], x ? 1'b0 : v};
    end
    return f;
  endfunction

  // one full write; checks waveform, latency, done, oe-low time and nack
  task automatic run_txn(input logic [15:0] d, input int glitch_k, input int xbit,
                         output logic [26:0] cap);
    int   errs, first_err, oe_low, ncap, qk;
    logic sc, sd, oe, care, prev_sc, exp_nack;
    errs = 0; first_err = -1; oe_low = 0; ncap = 0; prev_sc = 1'b1;
    cap = '0;
    data  = d;
    start = 1'b1;
    tick();
    start = 1'b0;
    data  = ~d;
`ifdef SCCB_ACK_CHECK_EN
    check("nack_clear_on_start", nack, 0);
`endif
    for (int k = 0; k < NQ * D; k++) begin
      qk = k / D;
      siod_in = (qk >= 2 && qk < 110 && ((qk - 2) / 4) == xbit);
      start   = (k == glitch_k);
      if (k == glitch_k) data = 16'hFFFF ^ d;
      model_q(d, qk, sc, sd, oe, care);
      if (sioc !== sc || siod_oe !== oe || (care && siod_out !== sd) ||
          busy !== 1'b1 || done !== 1'b0) begin
        errs++;
        if (first_err < 0) first_err = k;
      end
      if (siod_oe === 1'b0) oe_low++;
      if (sioc === 1'b1 && prev_sc === 1'b0 && ncap < 27) begin
        cap = {cap[25:0], siod_out};
        ncap++;
      end
      prev_sc = sioc;
      tick();
    end
    siod_in = 1'b0;
    start   = 1'b0;
    if (errs != 0) $display("  first waveform deviation at cycle %0d", first_err);
    check("waveform_errors", errs, 0);
    check("captured_bits", ncap, 27);
    check("oe_low_cycles", oe_low, 12 * D);
    check("done_at_latency", done, 1);
    check("busy_at_done", busy, 0);
`ifdef SCCB_ACK_CHECK_EN
    exp_nack = (xbit == 8 || xbit == 17 || xbit == 26);
`else
    exp_nack = 1'b0;
`endif
    check("nack_at_done", nack, exp_nack);
    tick();
    check("idle_after_done", {done, busy, sioc, siod_out, siod_oe}, 5'b00111);
  endtask

  initial begin
    logic [26:0] cap, expf, mask;
    logic [15:0] rd;
    int rises, dones, done1, rise2, busy_seen;
    logic pb;

    mask = 27'b111111110_111111110_111111110;

    vecs[0] = '{16'h1280, -1, -1, 8'h12, 8'h80};
    vecs[1] = '{16'h00FF, -1, -1, 8'h00, 8'hFF};
    vecs[2] = '{16'hA55A, 150, -1, 8'hA5, 8'h5A};
    vecs[3] = '{16'h3A01, -1, 17, 8'h3A, 8'h01};

    // reset, with start asserted to show it is ignored while in reset
    reset_n = 1'b0;
    start   = 1'b1;
    repeat (3) tick();
    check("rst_sioc", sioc, 1);
    check("rst_siod_out", siod_out, 1);
    check("rst_siod_oe", siod_oe, 1);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_nack", nack, 0);
    start   = 1'b0;
    reset_n = 1'b1;
    tick();
    check("idle_after_reset", {done, busy, sioc, siod_out, siod_oe}, 5'b00111);

    // table vectors, including a mid-transaction start and a NACK on phase 2
    for (int i = 0; i < 4; i++) begin
      run_txn(vecs[i].d, vecs[i].glitch, vecs[i].xbit, cap);
      check("byte_id", cap[26:19], DEV);
      check("byte_addr", cap[17:10], vecs[i].exp_addr);
      check("byte_val", cap[8:1], vecs[i].exp_val);
    end

    // nack (if any) holds while idle
    repeat (5) tick();
`ifdef SCCB_ACK_CHECK_EN
    check("nack_held_idle", nack, 1);
`else
    check("nack_held_idle", nack, 0);
`endif

    // randomized payloads against the frame model; siod_in high on a data bit
    for (int i = 0; i < 4; i++) begin
      rd = 16'($urandom);
      run_txn(rd, (i == 1) ? int'($urandom_range(20, 400)) : -1, (i == 2) ? 3 : -1, cap);
      expf = model_frame(rd);
      check("rand_frame", cap & mask, expf & mask);
    end

    // start held high for 600 cycles: exactly two transactions
    rises = 0; dones = 0; done1 = -1; rise2 = -1; pb = 1'b0;
    data  = 16'h1280;
    start = 1'b1;
    for (int c = 0; c < 1400; c++) begin
      tick();
      if (c == 600) start = 1'b0;
      if (busy === 1'b1 && pb === 1'b0) begin
        rises++;
        if (rises == 2) rise2 = c;
      end
      if (done === 1'b1) begin
        dones++;
        if (done1 < 0) done1 = c;
      end
      pb = busy;
    end
    check("held_start_txns", rises, 2);
    check("held_start_dones", dones, 2);
    check("held_first_done_cycle", done1, NQ * D);
    check("restart_gap", rise2 - done1, 2);

    // reset during phase 2 aborts silently
    data  = 16'hA5C3;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat ((2 + 12 * 4) * D) tick();
    reset_n = 1'b0;
    tick();
    check("abort_sioc", sioc, 1);
    check("abort_siod_out", siod_out, 1);
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    reset_n = 1'b1;
    busy_seen = 0; dones = 0;
    for (int c = 0; c < 600; c++) begin
      tick();
      if (busy === 1'b1) busy_seen++;
      if (done === 1'b1) dones++;
    end
    check("abort_no_done", dones, 0);
    check("abort_no_busy", busy_seen, 0);

    // clean transaction after the abort
    run_txn(16'h5E71, -1, -1, cap);
    check("post_abort_frame", cap & mask, model_frame(16'h5E71) & mask);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation time limit reached");
    $fatal(1);
  end

endmodule
